chan_mux_reg: RTL

CHAN_MUX_REG -- requirements
Module: chan_mux_reg

---
 rtl/chan_mux_reg.sv | 133 +++++++++++++
 1 files changed

// File: rtl/chan_mux_reg.sv
// Channel multiplexer feeding a one-entry registered output stage with beat counter.
// Define ROUND_ROBIN_EN to replace sel-based selection with a round-robin arbiter.
module chan_mux_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan,
    output logic [15:0]               xfer_count,
    output logic                      sel_err
);

    // Handshake: an input beat on channel i transfers on a rising edge when
    // in_valid[i] and in_ready[i] are both high; the output beat transfers when
    // out_valid and out_ready are both high. in_ready never depends on in_valid
    // in select mode, and only picks among valid channels in round-robin mode.

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [SEL_W-1:0]  grant;
    logic              grant_ok;
    logic              can_load;
    logic              accept;
    logic [WIDTH-1:0]  grant_data;

`ifdef ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr_q;
    logic             unused_sel;

    assign unused_sel = ^sel;
    assign sel_err    = 1'b0;

    // Channels above the pointer win first, then the lowest at or below it (wrap).
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!grant_ok && in_valid[i] && (SEL_W'(i) > ptr_q)) begin
                grant    = SEL_W'(i);
                grant_ok = 1'b1;
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!grant_ok && in_valid[i] && (SEL_W'(i) <= ptr_q)) begin
                grant    = SEL_W'(i);
                grant_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= SEL_W'(CHANNELS - 1);
        end else if (accept) begin
            ptr_q <= grant;
        end
    end
`else
    assign grant = sel;

    generate
        if (CHANNELS == (1 << SEL_W)) begin : g_full_range
            assign grant_ok = 1'b1;
        end else begin : g_part_range
            assign grant_ok = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (!grant_ok) begin
            sel_err <= 1'b1;
        end
    end
`endif

    assign can_load  = (state_q == EMPTY) | out_ready;
    assign out_valid = (state_q == FULL);

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = can_load & grant_ok & (grant == SEL_W'(i));
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = |(in_ready & in_valid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept)         state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            out_data   <= '0;
            out_chan   <= '0;
            xfer_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_data   <= grant_data;
                out_chan   <= grant;
                xfer_count <= xfer_count + 16'd1;
            end
        end
    end

endmodule
